// File: rtl/id_operand_stage.sv
// id_operand_stage: MIPS ID stage. It holds the IF/ID register and the
// instruction buffer, performs N-channel priority forwarding, detects
// load-use hazards, and resolves branches and jumps in ID.

// Forwarding mux for one source register. The lowest channel index wins,
// and register 0 always reads as zero.
module id_fwd_mux #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NFWD = 3
) (
  input  logic [AW-1:0]      src,
  input  logic [DW-1:0]      rf_data,
  input  logic [NFWD-1:0]    fwd_we,
  input  logic [NFWD*AW-1:0] fwd_waddr,
  input  logic [NFWD*DW-1:0] fwd_wdata,
  output logic [DW-1:0]      val
);
  // Scan from oldest to youngest so that a younger match overrides an older one.
  always_comb begin
    val = rf_data;
    for (int i = NFWD-1; i >= 0; i--)
      if (fwd_we[i] && fwd_waddr[i*AW +: AW] == src) val = fwd_wdata[i*DW +: DW];
    if (src == '0) val = '0;
  end
endmodule

module id_operand_stage #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NFWD = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         stall,
  input  logic               if_valid,
  input  logic [DW-1:0]      if_pc,
  input  logic [31:0]        inst_sram_rdata,
  output logic [AW-1:0]      rf_raddr1,
  output logic [AW-1:0]      rf_raddr2,
  input  logic [DW-1:0]      rf_rdata1,
  input  logic [DW-1:0]      rf_rdata2,
  input  logic [NFWD-1:0]    fwd_we,
  input  logic [NFWD*AW-1:0] fwd_waddr,
  input  logic [NFWD*DW-1:0] fwd_wdata,
  input  logic               fwd_is_load,
  output logic               id_valid,
  output logic [DW-1:0]      id_pc,
  output logic [31:0]        id_inst,
  output logic [DW-1:0]      src1_val,
  output logic [DW-1:0]      src2_val,
  output logic               stallreq,
  output logic               br_e,
  output logic [DW-1:0]      br_addr
);
  logic        ibuf_v;
  logic [31:0] ibuf;

  // Only the IF/ID and ID stop bits matter to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:3], stall[0]};

  // IF/ID register: stop IF/ID with ID running injects a bubble. A full stop holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
    end else if (stall[1] && !stall[2]) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
    end else if (!stall[1]) begin
      id_valid <= if_valid;
      id_pc    <= if_pc;
    end
  end

  // Instruction buffer: latch the SRAM word on the first stalled edge. The SRAM
  // output may move on while ID is frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      ibuf_v <= 1'b0;
      ibuf   <= '0;
    end else if (!stall[2]) begin
      ibuf_v <= 1'b0;
    end else if (!ibuf_v) begin
      ibuf_v <= 1'b1;
      ibuf   <= inst_sram_rdata;
    end
  end

  assign id_inst = !id_valid ? 32'd0 : (ibuf_v ? ibuf : inst_sram_rdata);

  logic [5:0]    opcode, func;
  logic [4:0]    rs, rt;
  logic [15:0]   imm;
  assign opcode = id_inst[31:26];
  assign rs     = id_inst[25:21];
  assign rt     = id_inst[20:16];
  assign func   = id_inst[5:0];
  assign imm    = id_inst[15:0];

  assign rf_raddr1 = AW'(rs);
  assign rf_raddr2 = AW'(rt);

  // One forwarding lane per source operand.
  logic [1:0][AW-1:0] lane_src;
  logic [1:0][DW-1:0] lane_rf, lane_val;
  assign lane_src = {rf_raddr2, rf_raddr1};
  assign lane_rf  = {rf_rdata2, rf_rdata1};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    id_fwd_mux #(.DW(DW), .AW(AW), .NFWD(NFWD)) u_fwd (
      .src       (lane_src[g]),
      .rf_data   (lane_rf[g]),
      .fwd_we    (fwd_we),
      .fwd_waddr (fwd_waddr),
      .fwd_wdata (fwd_wdata),
      .val       (lane_val[g])
    );
  end

  assign src1_val = lane_val[0];
  assign src2_val = lane_val[1];

  // Source usage. The shift-immediate forms carry shamt where rs would sit.
  logic is_rtype, use_rs, use_rt;
  assign is_rtype = (opcode == 6'h00);
  assign use_rs = !(opcode == 6'h02 || opcode == 6'h03 || opcode == 6'h0f ||
                    (is_rtype && (func == 6'h00 || func == 6'h02 || func == 6'h03)));
  assign use_rt = is_rtype || opcode == 6'h04 || opcode == 6'h05 || opcode[5:3] == 3'b101;

  // A load in EX cannot forward yet, so hold ID until its data reaches a later channel.
  logic [AW-1:0] waddr0;
  assign waddr0   = fwd_waddr[AW-1:0];
  assign stallreq = id_valid && fwd_is_load && fwd_we[0] && waddr0 != '0 &&
                    ((use_rs && waddr0 == rf_raddr1) || (use_rt && waddr0 == rf_raddr2));

  logic [DW-1:0] pc4, btgt, jtgt;
  assign pc4  = id_pc + DW'(4);
  assign btgt = pc4 + {{(DW-18){imm[15]}}, imm, 2'b00};
  assign jtgt = {pc4[DW-1:28], id_inst[25:0], 2'b00};

  // Branch/jump resolution on the forwarded operands.
  logic          taken;
  logic [DW-1:0] tgt;
  always_comb begin
    taken = 1'b0;
    tgt   = btgt;
    case (opcode)
      6'h00: if (func == 6'h08 || func == 6'h09) begin taken = 1'b1; tgt = src1_val; end
      6'h01: case (rt)
               5'b00000, 5'b10000: taken = src1_val[DW-1];
               5'b00001, 5'b10001: taken = !src1_val[DW-1];
               default:            taken = 1'b0;
             endcase
      6'h02, 6'h03: begin taken = 1'b1; tgt = jtgt; end
      6'h04: taken = (src1_val == src2_val);
      6'h05: taken = (src1_val != src2_val);
      6'h06: taken = src1_val[DW-1] || src1_val == '0;
      6'h07: taken = !src1_val[DW-1] && src1_val != '0;
      default: taken = 1'b0;
    endcase
  end

  assign br_e    = id_valid && !stallreq && taken;
  assign br_addr = br_e ? tgt : '0;
endmodule

// File: tb/tb_id_operand_stage.sv
// Directed-vector bench for id_operand_stage with hand-computed expectations.
module tb_id_operand_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        if_valid;
  logic [31:0] if_pc, inst_sram_rdata;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [2:0]  fwd_we;
  logic [14:0] fwd_waddr;
  logic [95:0] fwd_wdata;
  logic        fwd_is_load;
  logic        id_valid;
  logic [31:0] id_pc, id_inst, src1_val, src2_val, br_addr;
  logic        stallreq, br_e;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_operand_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
    .inst_sram_rdata(inst_sram_rdata), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata), .fwd_is_load(fwd_is_load), .id_valid(id_valid), .id_pc(id_pc),
    .id_inst(id_inst), .src1_val(src1_val), .src2_val(src2_val), .stallreq(stallreq),
    .br_e(br_e), .br_addr(br_addr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; stall = '0; if_valid = 1'b1; if_pc = 32'h100; inst_sram_rdata = 32'h0;
    rf_rdata1 = '0; rf_rdata2 = '0; fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0;
    fwd_is_load = 1'b0;
    tick(); tick();
    inst_sram_rdata = 32'h0800_0040;  // j: would be taken if ID looked valid
    #1;
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_inst", id_inst, 32'd0);
    chk("rst_br_e", 32'(br_e), 32'd0);
    chk("rst_br_addr", br_addr, 32'd0);
    rst = 1'b0;
    tick();
    chk("load_valid", 32'(id_valid), 32'd1);
    chk("load_pc", id_pc, 32'h100);

    // addu $2,$8,$9 : all three channels hit r8
    inst_sram_rdata = 32'h0109_1021;
    rf_rdata1 = 32'hAAAA; rf_rdata2 = 32'hBBBB;
    fwd_we = 3'b111; fwd_waddr = {5'd8, 5'd8, 5'd8};
    fwd_wdata = {32'h33, 32'h22, 32'h11};
    #1;
    chk("raddr1", 32'(rf_raddr1), 32'd8);
    chk("raddr2", 32'(rf_raddr2), 32'd9);
    chk("prio_ch0", src1_val, 32'h11);
    chk("prio_rt_rf", src2_val, 32'hBBBB);
    fwd_we = 3'b110; #1;
    chk("prio_ch1", src1_val, 32'h22);
    fwd_we = 3'b100; #1;
    chk("prio_ch2", src1_val, 32'h33);
    fwd_we = 3'b000; #1;
    chk("prio_rf", src1_val, 32'hAAAA);

    // or $3,$0,$0 with a load targeting r0 on ch0
    inst_sram_rdata = 32'h0000_1825;
    rf_rdata1 = 32'h1234; rf_rdata2 = 32'h5678;
    fwd_we = 3'b001; fwd_waddr = {5'd0, 5'd0, 5'd0}; fwd_wdata = {64'h0, 32'hDEAD};
    fwd_is_load = 1'b1;
    #1;
    chk("r0_src1", src1_val, 32'd0);
    chk("r0_src2", src2_val, 32'd0);
    chk("r0_no_stall", 32'(stallreq), 32'd0);

    // beq $5,$6,+3 with a load to r5 in EX
    inst_sram_rdata = 32'h10A6_0003;
    rf_rdata1 = 32'd0; rf_rdata2 = 32'd0;
    fwd_we = 3'b001; fwd_waddr = {5'd0, 5'd0, 5'd5}; fwd_is_load = 1'b1;
    #1;
    chk("lu_stall", 32'(stallreq), 32'd1);
    chk("lu_br_e", 32'(br_e), 32'd0);
    chk("lu_br_addr", br_addr, 32'd0);
    fwd_we = 3'b011; fwd_waddr = {5'd0, 5'd5, 5'd5}; #1;
    chk("lu_stall_older", 32'(stallreq), 32'd1);
    fwd_we = 3'b001; fwd_waddr = {5'd0, 5'd0, 5'd6}; #1;
    chk("lu_stall_rt", 32'(stallreq), 32'd1);
    fwd_is_load = 1'b0; fwd_we = 3'b110; fwd_waddr = {5'd6, 5'd5, 5'd0};
    fwd_wdata = {32'd7, 32'd7, 32'd0};
    tick();
    chk("beq_stall", 32'(stallreq), 32'd0);
    chk("beq_br_e", 32'(br_e), 32'd1);
    chk("beq_br_addr", br_addr, 32'h110);
    // addu writes r2; a load to r2 is not a source, so no stall
    inst_sram_rdata = 32'h0109_1021;
    fwd_is_load = 1'b1; fwd_we = 3'b001; fwd_waddr = {5'd0, 5'd0, 5'd2}; #1;
    chk("lu_dest_only", 32'(stallreq), 32'd0);

    // branch set, a = 0xFFFFFFFF from the regfile
    fwd_is_load = 1'b0; fwd_we = 3'b000;
    rf_rdata1 = 32'hFFFF_FFFF; rf_rdata2 = 32'd0;
    inst_sram_rdata = 32'h0420_0010; #1;  // bltz $1,+16
    chk("bltz_e", 32'(br_e), 32'd1);
    chk("bltz_addr", br_addr, 32'h144);
    inst_sram_rdata = 32'h0421_0010; #1;  // bgez $1,+16
    chk("bgez_e", 32'(br_e), 32'd0);
    inst_sram_rdata = 32'h1C20_0010; #1;  // bgtz
    chk("bgtz_e", 32'(br_e), 32'd0);
    chk("bgtz_addr", br_addr, 32'd0);
    inst_sram_rdata = 32'h1820_0010; #1;  // blez
    chk("blez_addr", br_addr, 32'h144);
    inst_sram_rdata = 32'h1422_FFFC; #1;  // bne $1,$2,-4
    chk("bne_addr", br_addr, 32'hF4);
    inst_sram_rdata = 32'h0020_0008; #1;  // jr $1
    chk("jr_addr", br_addr, 32'hFFFF_FFFF);
    inst_sram_rdata = 32'h0800_0040; #1;  // j 0x40
    chk("j_e", 32'(br_e), 32'd1);
    chk("j_addr", br_addr, 32'h100);

    // multi-cycle stall: ibuf freezes the first word
    stall = 6'b000110; inst_sram_rdata = 32'hAAAA_0001; if_pc = 32'h200;
    tick();
    inst_sram_rdata = 32'hBBBB_0002; #1;
    chk("stall_inst1", id_inst, 32'hAAAA_0001);
    chk("stall_pc", id_pc, 32'h100);
    tick();
    inst_sram_rdata = 32'hCCCC_0003; #1;
    chk("stall_inst2", id_inst, 32'hAAAA_0001);
    tick();
    inst_sram_rdata = 32'hDDDD_0004; #1;
    chk("stall_inst3", id_inst, 32'hAAAA_0001);
    stall = 6'b000000;
    tick();
    chk("release_inst", id_inst, 32'hDDDD_0004);
    chk("release_pc", id_pc, 32'h200);

    // bubble
    stall = 6'b000010; inst_sram_rdata = 32'h0800_0040;
    tick();
    chk("bubble_valid", 32'(id_valid), 32'd0);
    chk("bubble_pc", id_pc, 32'd0);
    chk("bubble_inst", id_inst, 32'd0);
    chk("bubble_br_e", 32'(br_e), 32'd0);

    // reset in the middle of a stall
    stall = 6'b000000;
    tick();
    stall = 6'b000110; inst_sram_rdata = 32'h1111_0000;
    tick();
    rst = 1'b1; inst_sram_rdata = 32'h2222_0000;
    tick();
    chk("rst_hold_pc", id_pc, 32'd0);
    chk("rst_hold_valid", 32'(id_valid), 32'd0);
    rst = 1'b0; stall = 6'b000100; inst_sram_rdata = 32'h3333_0000;
    tick();
    inst_sram_rdata = 32'h4444_0000; #1;
    chk("rst_ibuf_clear", id_inst, 32'h3333_0000);
    chk("rst_reload_pc", id_pc, 32'h200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
